ai_paddle_tracker: RTL and testbench

//  Parametrised computer-opponent paddle controller and next generation of the AI paddle driver.

---
 rtl/ai_paddle_tracker_if.sv | 29 ++
 rtl/ai_paddle_tracker.sv | 140 ++++++++++++++
 tb/tb_ai_paddle_tracker.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ai_paddle_tracker_if.sv
// Signal bundle between the game FSM / ball logic and the computer-opponent paddle tracker.
// The master side drives ball state, mode and events; the slave side returns the step requests.
interface ai_paddle_tracker_if #(
    parameter int CW = 11
);
    logic          en;
    logic [1:0]    mode;
    logic [1:0]    level;
    logic          xh;
    logic          turn;
    logic          hit;
    logic          wall;
    logic          start_state;
    logic [CW-1:0] by;
    logic [CW-1:0] py;
    logic          p;
    logic          m;
    logic          tracking;

    modport master (
        output en, mode, level, xh, turn, hit, wall, start_state, by, py,
        input  p, m, tracking
    );

    modport slave (
        input  en, mode, level, xh, turn, hit, wall, start_state, by, py,
        output p, m, tracking
    );
endinterface

// File: rtl/ai_paddle_tracker.sv
// Computer-opponent paddle controller: waits a level-dependent reaction delay, then steers
// the paddle toward the ball with an LFSR-derived aiming dead band around the ball position.
//
// state | meaning
// IDLE  | ball not approaching; hold paddle
// REACT | ball approaching; reaction-delay countdown, hold paddle
// TRACK | steering paddle toward ball +/- aiming error
module ai_paddle_tracker #(
    parameter int          CW         = 11,
    parameter int          ERRW       = 6,
    parameter int          REACT_BASE = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input logic                clk,
    input logic                rst,
    ai_paddle_tracker_if.slave bus
);

    localparam int CNTW = $clog2(REACT_BASE * 3 + 1);
    localparam logic [CW:0] MAXC = {1'b0, {CW{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REACT = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [15:0]       lfsr;
    logic [ERRW-1:0]   err;
    logic              wall_lat;
    logic              p_q;
    logic              m_q;
    logic              tracking_q;

    logic              approach;
    logic              advance;
    logic [15:0]       lfsr_next;
    logic [ERRW-1:0]   err_next;
    logic [CNTW-1:0]   react_load;
    logic [CW:0]       by_x;
    logic [CW:0]       py_x;
    logic [CW:0]       err_x;
    logic [CW:0]       lo;
    logic [CW:0]       hi;
    logic [CW:0]       hi_sum;

    always_comb begin
        approach   = ((bus.mode == 2'd0) && bus.xh)
                   || ((bus.mode == 2'd1) && wall_lat)
                   || ((bus.mode == 2'd2) && bus.turn);
        advance    = bus.hit || ((bus.mode == 2'd2) && bus.wall);
        lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        err_next   = (bus.level == 2'd3) ? '0 : (lfsr_next[ERRW-1:0] >> bus.level);
        react_load = CNTW'(REACT_BASE * (3 - int'(bus.level)) - 1);
    end

    // Dead band is computed one bit wider so by+err cannot wrap and by-err cannot underflow.
    always_comb begin
        by_x   = {1'b0, bus.by};
        py_x   = {1'b0, bus.py};
        err_x  = (CW+1)'(err);
        lo     = (by_x >= err_x) ? (by_x - err_x) : '0;
        hi_sum = by_x + err_x;
        hi     = (hi_sum > MAXC) ? MAXC : hi_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lfsr       <= SEED;
            err        <= '0;
            wall_lat   <= 1'b0;
            p_q        <= 1'b1;
            m_q        <= 1'b1;
            tracking_q <= 1'b0;
        end else if (!bus.en) begin
            p_q <= 1'b1;
            m_q <= 1'b1;
        end else begin
            wall_lat <= bus.wall || (wall_lat && !bus.start_state);
            if (advance) begin
                lfsr <= lfsr_next;
                err  <= err_next;
            end
            case (state)
                IDLE: begin
                    p_q <= 1'b1;
                    m_q <= 1'b1;
                    if (approach) begin
                        if (bus.level == 2'd3) begin
                            state      <= TRACK;
                            tracking_q <= 1'b1;
                        end else begin
                            state <= REACT;
                            cnt   <= react_load;
                        end
                    end
                end
                REACT: begin
                    p_q <= 1'b1;
                    m_q <= 1'b1;
                    if (!approach) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state      <= TRACK;
                        tracking_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                TRACK: begin
                    if (!approach) begin
                        state      <= IDLE;
                        tracking_q <= 1'b0;
                        p_q        <= 1'b1;
                        m_q        <= 1'b1;
                    end else begin
                        // lo <= hi always holds, so at most one request goes low
                        p_q <= !(py_x < lo);
                        m_q <= !(py_x > hi);
                    end
                end
                default: begin
                    state      <= IDLE;
                    tracking_q <= 1'b0;
                    p_q        <= 1'b1;
                    m_q        <= 1'b1;
                end
            endcase
        end
    end

    assign bus.p        = p_q;
    assign bus.m        = m_q;
    assign bus.tracking = tracking_q;

endmodule

// File: tb/tb_ai_paddle_tracker.sv
// Scenario bench for ai_paddle_tracker: expected {p,m,tracking} words are queued as
// stimulus is applied and checked after each edge.
module tb_ai_paddle_tracker;

    localparam int CW = 11;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [2:0] exp_q[$];
    logic [2:0] e;

    ai_paddle_tracker_if #(.CW(CW)) bus ();

    ai_paddle_tracker #(.CW(CW), .ERRW(6), .REACT_BASE(8), .SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.mode = 2'd3;
        exp_q.push_back(3'b110);
        tick();
        rst = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if ({bus.p, bus.m, bus.tracking} !== e) begin
            miscompares++;
            $display("FAIL reset_out got=%b want=%b", {bus.p, bus.m, bus.tracking}, e);
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(3'b110);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e) begin
                miscompares++;
                $display("FAIL mode3_idle[%0d] got=%b want=%b", k, {bus.p, bus.m, bus.tracking}, e);
            end
        end
        vectors++;
        if (dut.lfsr !== 16'hACE1) begin
            miscompares++;
            $display("FAIL reset_lfsr got=%h want=%h", dut.lfsr, 16'hACE1);
        end
    endtask

    task automatic test_track_hard();
        logic [2:0] want[5] = '{3'b111, 3'b011, 3'b101, 3'b111, 3'b110};
        int         pys[5]  = '{100, 100, 500, 400, 400};
        bus.level = 2'd3;
        bus.mode  = 2'd2;
        bus.by    = 11'd400;
        for (int k = 0; k < 5; k++) begin
            bus.turn = (k < 4);
            bus.py   = CW'(pys[k]);
            exp_q.push_back(want[k]);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e) begin
                miscompares++;
                $display("FAIL track_hard[%0d] got=%b want=%b", k, {bus.p, bus.m, bus.tracking}, e);
            end
        end
    endtask

    task automatic test_react();
        int n;
        bus.mode = 2'd0;
        bus.by   = 11'd400;
        bus.py   = 11'd100;
        for (int lv = 0; lv < 3; lv++) begin
            bus.level = 2'(lv);
            bus.xh    = 1'b1;
            n = 1 + 8 * (3 - lv);
            for (int k = 0; k < n; k++)
                exp_q.push_back((k == n - 1) ? 3'b111 : 3'b110);
            exp_q.push_back(3'b011);
            for (int k = 0; k <= n; k++) begin
                tick();
                e = exp_q.pop_front();
                vectors++;
                if ({bus.p, bus.m, bus.tracking} !== e) begin
                    miscompares++;
                    $display("FAIL react_lv%0d[%0d] got=%b want=%b", lv, k, {bus.p, bus.m, bus.tracking}, e);
                end
            end
            bus.xh = 1'b0;
            exp_q.push_back(3'b110);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e) begin
                miscompares++;
                $display("FAIL react_exit_lv%0d got=%b want=%b", lv, {bus.p, bus.m, bus.tracking}, e);
            end
        end
        // Abort the countdown part-way, then re-arm: the full delay must be served again.
        bus.level = 2'd0;
        bus.xh = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(3'b110);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e) begin
                miscompares++;
                $display("FAIL react_part[%0d] got=%b want=%b", k, {bus.p, bus.m, bus.tracking}, e);
            end
        end
        bus.xh = 1'b0;
        exp_q.push_back(3'b110);
        tick();
        bus.xh = 1'b1;
        for (int k = 0; k < 25; k++)
            exp_q.push_back((k == 24) ? 3'b111 : 3'b110);
        for (int k = 0; k < 26; k++) begin
            if (k > 0) tick();
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e) begin
                miscompares++;
                $display("FAIL react_rearm[%0d] got=%b want=%b", k, {bus.p, bus.m, bus.tracking}, e);
            end
        end
        bus.xh = 1'b0;
        tick();
    endtask

    task automatic test_clamp();
        logic [15:0] mlfsr;
        logic [5:0]  merr;
        logic [1:0]  lv;
        int          bys[6]  = '{10, 10, 10, 2040, 2040, 2040};
        int          pys[6]  = '{0, 50, 51, 2047, 2000, 1999};
        logic [2:0]  want[6] = '{3'b111, 3'b111, 3'b101, 3'b111, 3'b111, 3'b011};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mlfsr = 16'hACE1;
        merr  = '0;
        bus.xh = 1'b0;
        bus.turn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i >= 4 && merr == 6'd40) break;
            lv        = (i == 2 || i == 3) ? 2'd2 : 2'd0;
            bus.level = lv;
            bus.mode  = (i < 2) ? 2'd2 : 2'd0;
            bus.hit   = (i != 1);
            bus.wall  = (i < 2);
            mlfsr = lfsr_step(mlfsr);
            merr  = mlfsr[5:0] >> lv;
            exp_q.push_back(3'b110);
            tick();
            bus.hit  = 1'b0;
            bus.wall = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e || dut.lfsr !== mlfsr || dut.err !== merr) begin
                miscompares++;
                $display("FAIL err_gen[%0d] out=%b/%b lfsr=%h/%h err=%0d/%0d", i,
                         {bus.p, bus.m, bus.tracking}, e, dut.lfsr, mlfsr, dut.err, merr);
            end
        end
        vectors++;
        if (dut.err !== 6'd40) begin
            miscompares++;
            $display("FAIL err_seek got=%0d want=40", dut.err);
        end
        bus.level = 2'd0;
        bus.mode  = 2'd0;
        bus.xh    = 1'b1;
        bus.by    = 11'd10;
        bus.py    = 11'd0;
        for (int k = 0; k < 25; k++) begin
            exp_q.push_back((k == 24) ? 3'b111 : 3'b110);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e) begin
                miscompares++;
                $display("FAIL clamp_react[%0d] got=%b want=%b", k, {bus.p, bus.m, bus.tracking}, e);
            end
        end
        for (int k = 0; k < 6; k++) begin
            bus.by = CW'(bys[k]);
            bus.py = CW'(pys[k]);
            exp_q.push_back(want[k]);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e) begin
                miscompares++;
                $display("FAIL clamp[%0d] by=%0d py=%0d got=%b want=%b", k, bys[k], pys[k],
                         {bus.p, bus.m, bus.tracking}, e);
            end
        end
        bus.xh = 1'b0;
        tick();
    endtask

    task automatic test_wall_latch();
        logic [2:0] want[7] = '{3'b110, 3'b111, 3'b011, 3'b011, 3'b110, 3'b110, 3'b111};
        logic       wl[7]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mode  = 2'd1;
        bus.level = 2'd3;
        bus.by    = 11'd400;
        bus.py    = 11'd100;
        for (int k = 0; k < 7; k++) begin
            bus.wall        = (k == 0 || k == 5);
            bus.start_state = (k == 0 || k == 3);
            exp_q.push_back(want[k]);
            tick();
            bus.wall        = 1'b0;
            bus.start_state = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e || dut.wall_lat !== wl[k]) begin
                miscompares++;
                $display("FAIL wall_latch[%0d] out=%b/%b wall_lat=%b/%b", k,
                         {bus.p, bus.m, bus.tracking}, e, dut.wall_lat, wl[k]);
            end
        end
    endtask

    task automatic test_enable();
        bus.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.hit         = k[0];
            bus.start_state = 1'b1;
            exp_q.push_back(3'b111);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if ({bus.p, bus.m, bus.tracking} !== e) begin
                miscompares++;
                $display("FAIL en_low[%0d] got=%b want=%b", k, {bus.p, bus.m, bus.tracking}, e);
            end
        end
        bus.hit         = 1'b0;
        bus.start_state = 1'b0;
        vectors++;
        if (dut.lfsr !== 16'hACE1 || dut.wall_lat !== 1'b1) begin
            miscompares++;
            $display("FAIL en_hold lfsr=%h want=%h wall_lat=%b want=1", dut.lfsr, 16'hACE1, dut.wall_lat);
        end
        bus.en = 1'b1;
        exp_q.push_back(3'b011);
        tick();
        e = exp_q.pop_front();
        vectors++;
        if ({bus.p, bus.m, bus.tracking} !== e) begin
            miscompares++;
            $display("FAIL en_resume got=%b want=%b", {bus.p, bus.m, bus.tracking}, e);
        end
        bus.en = 1'b0;
        rst    = 1'b1;
        exp_q.push_back(3'b110);
        tick();
        rst = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if ({bus.p, bus.m, bus.tracking} !== e || dut.wall_lat !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_over_en got=%b want=%b wall_lat=%b", {bus.p, bus.m, bus.tracking}, e, dut.wall_lat);
        end
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        bus.en          = 1'b0;
        bus.mode        = 2'd3;
        bus.level       = 2'd0;
        bus.xh          = 1'b0;
        bus.turn        = 1'b0;
        bus.hit         = 1'b0;
        bus.wall        = 1'b0;
        bus.start_state = 1'b0;
        bus.by          = '0;
        bus.py          = '0;
        test_reset();
        test_track_hard();
        test_react();
        test_clamp();
        test_wall_latch();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
